// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUCtrl operation codes and execution-unit state encoding.
// Imported by the ALU control decoder, the combinational core and the exec unit.
package alu_pkg;

  localparam logic [4:0] ALU_AND = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00001;
  localparam logic [4:0] ALU_ADD = 5'b00010;
  localparam logic [4:0] ALU_SUB = 5'b00110;
  localparam logic [4:0] ALU_SLT = 5'b00111;
  localparam logic [4:0] ALU_NOR = 5'b01000;
  localparam logic [4:0] ALU_XOR = 5'b01001;
  localparam logic [4:0] ALU_SLL = 5'b01010;
  localparam logic [4:0] ALU_SRL = 5'b10000;
  localparam logic [4:0] ALU_SRA = 5'b10001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_t;

  function automatic logic is_shift(input logic [4:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU operations. Shift codes pass operand B through unchanged; this is
// the zero-distance shift result, since multi-bit shifting is sequenced by the exec unit.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [4:0]       ctrl,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             illegal
);

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic signed [WIDTH-1:0] sum_s;
  logic signed [WIDTH-1:0] diff_s;
  logic                    lt;

  assign a_s    = a;
  assign b_s    = b;
  assign sum_s  = a_s + b_s;
  assign diff_s = a_s - b_s;
  assign lt     = sign ? (a_s < b_s) : (a < b);

  // Signed overflow from operand and result sign bits
  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    illegal  = 1'b0;
    case (ctrl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_NOR: result = ~(a | b);
      ALU_XOR: result = a ^ b;
      ALU_ADD: begin
        result   = sum_s;
        overflow = sign && add_ovf(a[WIDTH-1], b[WIDTH-1], sum_s[WIDTH-1]);
      end
      ALU_SUB: begin
        result   = diff_s;
        overflow = sign && sub_ovf(a[WIDTH-1], b[WIDTH-1], diff_s[WIDTH-1]);
      end
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, lt};
      ALU_SLL, ALU_SRL, ALU_SRA: result = b;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle ops via alu_comb_core, shifts one bit per cycle,
// with a valid/ready handshake on both request and result sides.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       ALUCtrl,
  input  logic             Sign,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_overflow,
  output logic             out_illegal
);

  alu_state_t       state, state_nxt;
  logic [4:0]       op_p1;
  logic [WIDTH-1:0] sh_p1;
  logic [SHW-1:0]   cnt_p1;
  logic [WIDTH-1:0] sh_next;
  logic [WIDTH-1:0] core_result;
  logic             core_ovf;
  logic             core_ill;
  logic             accept;
  logic             shift_start;
  logic             shift_last;

  alu_comb_core #(.WIDTH(WIDTH)) u_core (
    .ctrl     (ALUCtrl),
    .sign     (Sign),
    .a        (in_a),
    .b        (in_b),
    .result   (core_result),
    .overflow (core_ovf),
    .illegal  (core_ill)
  );

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign accept      = in_valid && in_ready;
  assign shift_start = accept && is_shift(ALUCtrl) && (shamt != '0);
  assign shift_last  = (state == SHIFT) && (cnt_p1 == SHW'(1));

  always_comb begin
    case (op_p1)
      ALU_SLL: sh_next = {sh_p1[WIDTH-2:0], 1'b0};
      ALU_SRA: sh_next = {sh_p1[WIDTH-1], sh_p1[WIDTH-1:1]};
      default: sh_next = {1'b0, sh_p1[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = shift_start ? SHIFT : DONE;
      SHIFT:   if (shift_last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt_p1       <= '0;
      out_result   <= '0;
      out_zero     <= 1'b0;
      out_overflow <= 1'b0;
      out_illegal  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (shift_start) cnt_p1 <= shamt;
      else if (state == SHIFT) cnt_p1 <= cnt_p1 - SHW'(1);
      // Result registers only load on completion, so they hold throughout DONE
      if (accept && !shift_start) begin
        out_result   <= core_result;
        out_zero     <= (core_result == '0);
        out_overflow <= core_ovf;
        out_illegal  <= core_ill;
      end else if (shift_last) begin
        out_result   <= sh_next;
        out_zero     <= (sh_next == '0);
        out_overflow <= 1'b0;
        out_illegal  <= 1'b0;
      end
    end
  end

  // Shift datapath: loaded on accept, stepped once per cycle in SHIFT
  always_ff @(posedge clk) begin
    if (shift_start) begin
      sh_p1 <= in_b;
      op_p1 <= ALUCtrl;
    end else if (state == SHIFT) begin
      sh_p1 <= sh_next;
    end
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width.
REQ-002 SHALL have parameter SHW, default 5: shift-amount width, equal to log2(WIDTH).
REQ-003 SHALL have port clk  in  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  in  1: request present.
REQ-006 SHALL have port in_ready  out  1: unit accepts a request.
REQ-007 SHALL have port ALUCtrl  in  5: operation code produced by the ALU control decoder.
REQ-008 SHALL have port Sign  in  1: 1 = signed add/sub/slt, 0 = unsigned.
REQ-009 SHALL have port in_a  in  WIDTH: operand A (rs).
REQ-010 SHALL have port in_b  in  WIDTH: operand B (rt or immediate); this is the value shifted by shift operations.
REQ-011 SHALL have port shamt  in  SHW: shift amount.
REQ-012 SHALL have port out_valid  out  1: result present.
REQ-013 SHALL have port out_ready  in  1: consumer accepts the result.
REQ-014 SHALL have port out_result  out  WIDTH: result.
REQ-015 SHALL have port out_zero  out  1: out_result == 0.
REQ-016 SHALL have port out_overflow  out  1: signed add/sub overflow.
REQ-017 SHALL have port out_illegal  out  1: ALUCtrl was not a defined code.

Function
REQ-018 SHALL decode ALUCtrl codes as: and 00000, or 00001, add 00010, sub 00110, slt 00111, nor 01000, xor 01001, sll 01010, srl 10000, sra 10001.
REQ-019 SHALL implement a state machine with states IDLE, SHIFT, DONE; in_ready SHALL be 1 only in IDLE.
REQ-020 SHALL accept a request on a rising edge when in_valid && in_ready, capturing all inputs on that edge.
REQ-021 On accept with a non-shift code, or with a shift code and shamt == 0, SHALL register the result and enter DONE; out_valid is then high in the next cycle (latency 1).
REQ-022 On accept with a shift code and shamt == k > 0, SHALL load shift register = in_b and count = k, then enter SHIFT.
REQ-023 In SHIFT, each edge SHALL shift by one bit and decrement count; on the edge where count reaches 0 it SHALL enter DONE (latency k).
REQ-024 srl SHALL fill vacated bits with zero; sra SHALL fill them with the MSB; sll SHALL fill with zero.
REQ-025 add/sub SHALL wrap modulo 2^WIDTH.
REQ-026 out_overflow SHALL be 1 only when Sign = 1, the operation is add/sub, and the signed result overflows.
REQ-027 slt SHALL return 1 or 0 using a signed compare when Sign = 1 and an unsigned compare when Sign = 0.
REQ-028 An undefined ALUCtrl code SHALL give out_result = 0, out_illegal = 1, latency 1.
REQ-029 In DONE, out_valid SHALL be 1 and all outputs SHALL be held stable until out_valid && out_ready.
REQ-030 On that handshake edge the unit SHALL return to IDLE; no request is accepted on the same edge.
REQ-031 out_zero, out_overflow and out_illegal SHALL be registered alongside out_result.
REQ-032 Input changes while in SHIFT or DONE SHALL have no effect.

Reset
REQ-033 Reset low SHALL immediately force state IDLE, out_valid = 0, out_result = 0, out_zero = 0, out_overflow = 0, out_illegal = 0, and count = 0.
REQ-034 Reset asserted mid-SHIFT or mid-DONE SHALL abort and discard the operation.
REQ-035 After reset release, in_ready SHALL be 1 in the first cycle.

Structure
REQ-036 The ALUCtrl code constants and the state encoding SHALL reside in the shared package alu_pkg, used by both the control decoder and this unit.
REQ-037 Combinational single-cycle operations SHALL be in sub-module alu_comb_core; sequencing and shifting SHALL be in alu_exec_unit.

Verification
REQ-038 add, Sign = 1, a = 0x7FFFFFFF, b = 1 -> result 0x80000000, out_overflow = 1, out_valid one cycle after accept.
REQ-039 sra, b = 0x80000000, shamt = 4 -> result 0xF8000000, out_valid 4 cycles after accept, in_ready = 0 throughout.
REQ-040 slt, a = 0xFFFFFFFF, b = 1: Sign = 1 -> result 1; Sign = 0 -> result 0.
REQ-041 sub, a = b = 5 with out_ready held low for 3 cycles -> result 0 and out_zero = 1 held stable; return to IDLE on the edge out_ready rises.
REQ-042 ALUCtrl = 11111 -> out_illegal = 1, result 0; reset pulsed low mid-way through sll with shamt = 31 -> out_valid = 0 and in_ready = 1 after release.
